// File: rtl/spgd_meas_seq.sv
// spgd_meas_seq: sequences one SPGD measurement iteration.
// Applies +delta, settles, acquires J+, then the same for -delta and J-,
// and reports DELTA_J = J+ - J- with a one-cycle RESULT_VALID pulse.
// A single down-counter is shared between the settle and timeout intervals.
module spgd_meas_seq #(
    parameter int FP_WIDTH       = 64,
    parameter int SETTLE_CYCLES  = 256,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                ADC_CLK,
    input  logic                RST_N,
    input  logic                START,
    output logic                BUSY,
    output logic [1:0]          PERTURB_SEL,
    output logic                ADC_EN,
    input  logic                ADC_VALID,
    input  logic [FP_WIDTH-1:0] ADC_DATA,
    output logic [FP_WIDTH-1:0] J_PLUS,
    output logic [FP_WIDTH-1:0] J_MINUS,
    output logic [FP_WIDTH-1:0] DELTA_J,
    output logic                RESULT_VALID,
    output logic                TIMEOUT_ERR
);

    localparam logic [CNT_WIDTH-1:0] SETTLE_LD  = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LD = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE_P, S_MEAS_P, S_SETTLE_M, S_MEAS_M, S_CALC
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [FP_WIDTH-1:0]   j_plus_q, j_plus_d;
    logic [FP_WIDTH-1:0]   j_minus_q, j_minus_d;
    logic [FP_WIDTH-1:0]   delta_j_q, delta_j_d;
    logic                  busy_q, busy_d;
    logic [1:0]            psel_q, psel_d;
    logic                  adc_en_q, adc_en_d;
    logic                  rv_q, rv_d;
    logic                  terr_q, terr_d;

    // Next-state, counter and capture logic; control outputs are decoded from
    // the next state so they change in the same cycle as the state itself.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        j_plus_d  = j_plus_q;
        j_minus_d = j_minus_q;
        delta_j_d = delta_j_q;
        terr_d    = terr_q;
        rv_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_SETTLE_P;
                    cnt_d   = SETTLE_LD;
                    terr_d  = 1'b0;
                end
            end
            S_SETTLE_P, S_SETTLE_M: begin
                if (cnt_q == '0) begin
                    state_d = (state_q == S_SETTLE_P) ? S_MEAS_P : S_MEAS_M;
                    cnt_d   = TIMEOUT_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_MEAS_P, S_MEAS_M: begin
                // A strobe on the last allowed cycle still counts as a capture.
                if (ADC_VALID) begin
                    if (state_q == S_MEAS_P) begin
                        j_plus_d = ADC_DATA;
                        state_d  = S_SETTLE_M;
                        cnt_d    = SETTLE_LD;
                    end else begin
                        j_minus_d = ADC_DATA;
                        state_d   = S_CALC;
                        cnt_d     = '0;
                    end
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_CALC: begin
                // Plain wrap-around subtraction; no saturation.
                delta_j_d = j_plus_q - j_minus_q;
                rv_d      = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d   = (state_d != S_IDLE);
        adc_en_d = (state_d == S_MEAS_P) || (state_d == S_MEAS_M);
        if ((state_d == S_SETTLE_P) || (state_d == S_MEAS_P))
            psel_d = 2'b01;
        else if ((state_d == S_SETTLE_M) || (state_d == S_MEAS_M))
            psel_d = 2'b10;
        else
            psel_d = 2'b00;
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge ADC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            j_plus_q  <= '0;
            j_minus_q <= '0;
            delta_j_q <= '0;
            busy_q    <= 1'b0;
            psel_q    <= 2'b00;
            adc_en_q  <= 1'b0;
            rv_q      <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            j_plus_q  <= j_plus_d;
            j_minus_q <= j_minus_d;
            delta_j_q <= delta_j_d;
            busy_q    <= busy_d;
            psel_q    <= psel_d;
            adc_en_q  <= adc_en_d;
            rv_q      <= rv_d;
            terr_q    <= terr_d;
        end
    end

    assign BUSY         = busy_q;
    assign PERTURB_SEL  = psel_q;
    assign ADC_EN       = adc_en_q;
    assign J_PLUS       = j_plus_q;
    assign J_MINUS      = j_minus_q;
    assign DELTA_J      = delta_j_q;
    assign RESULT_VALID = rv_q;
    assign TIMEOUT_ERR  = terr_q;

endmodule

// File: tb/tb_spgd_meas_seq.sv
// Bench for spgd_meas_seq: per-cycle control timeline checks plus a
// scoreboard of expected {J+, J-, DELTA_J} popped on every RESULT_VALID.
module tb_spgd_meas_seq;

    localparam int S  = 4;
    localparam int TO = 8;

    logic        ADC_CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic        BUSY;
    logic [1:0]  PERTURB_SEL;
    logic        ADC_EN;
    logic        ADC_VALID;
    logic [63:0] ADC_DATA;
    logic [63:0] J_PLUS, J_MINUS, DELTA_J;
    logic        RESULT_VALID;
    logic        TIMEOUT_ERR;

    spgd_meas_seq #(
        .FP_WIDTH(64), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)
    ) dut (
        .ADC_CLK(ADC_CLK), .RST_N(RST_N), .START(START), .BUSY(BUSY),
        .PERTURB_SEL(PERTURB_SEL), .ADC_EN(ADC_EN), .ADC_VALID(ADC_VALID),
        .ADC_DATA(ADC_DATA), .J_PLUS(J_PLUS), .J_MINUS(J_MINUS),
        .DELTA_J(DELTA_J), .RESULT_VALID(RESULT_VALID), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 ADC_CLK = ~ADC_CLK;

    typedef struct packed {
        logic [63:0] jp;
        logic [63:0] jm;
        logic [63:0] dj;
    } sb_t;

    sb_t         sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        exp_terr = 1'b0;
    logic [63:0] last_jp = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ctl_now();
        return {BUSY, PERTURB_SEL, ADC_EN, RESULT_VALID, TIMEOUT_ERR};
    endfunction

    // Scoreboard consumer: every result pulse must match the oldest expectation.
    always @(negedge ADC_CLK) begin
        if (RST_N && RESULT_VALID) begin
            if (sb.size() == 0) begin
                chk("rv_unexpected", 64'd1, 64'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("delta_j", DELTA_J, e.dj);
                chk("j_plus",  J_PLUS,  e.jp);
                chk("j_minus", J_MINUS, e.jm);
            end
        end
    end

    // Idle cycles with junk ADC strobes that must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ADC_CLK); #1;
            ADC_VALID = 1'b1;
            ADC_DATA  = {$urandom, $urandom};
            @(negedge ADC_CLK);
            chk("idle_ctl", 64'(ctl_now()), 64'({1'b0, 2'b00, 1'b0, 1'b0, exp_terr}));
            chk("idle_jp", J_PLUS, last_jp);
        end
    endtask

    // One full iteration; lp/lm are MEAS lengths including the strobe cycle.
    // Returns at the falling edge of the RESULT_VALID cycle.
    task automatic iter(input logic [63:0] jp, input logic [63:0] jm,
                        input int lp, input int lm, input bit spur, input bit hold);
        int          t;
        logic [5:0]  e;
        sb_t         ent;
        t = 2*S + lp + lm + 2;
        START     = 1'b1;
        ADC_VALID = 1'b0;
        @(posedge ADC_CLK); #1;
        exp_terr = 1'b0;
        for (int c = 1; c <= t; c++) begin
            if (c > 1) begin @(posedge ADC_CLK); #1; end
            START     = hold || (spur && (c == 3 || c == S+lp+2));
            ADC_VALID = 1'b0;
            ADC_DATA  = {$urandom, $urandom};
            if (c == S+lp) begin
                ADC_VALID = 1'b1; ADC_DATA = jp;
            end else if (c == 2*S+lp+lm) begin
                ADC_VALID = 1'b1; ADC_DATA = jm;
                ent.jp = jp; ent.jm = jm; ent.dj = jp - jm;
                sb.push_back(ent);
            end else if (spur && (c == 2 || c == S+lp+1)) begin
                ADC_VALID = 1'b1;
            end
            if      (c <= S)          e = {1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
            else if (c <= S+lp)       e = {1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
            else if (c <= 2*S+lp)     e = {1'b1, 2'b10, 1'b0, 1'b0, 1'b0};
            else if (c <= 2*S+lp+lm)  e = {1'b1, 2'b10, 1'b1, 1'b0, 1'b0};
            else if (c == t-1)        e = {1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
            else                      e = {1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
            @(negedge ADC_CLK);
            chk($sformatf("ctl_c%0d", c), 64'(ctl_now()), 64'(e));
            if (c == S+lp+1) chk("jp_capt", J_PLUS, jp);
        end
        ADC_VALID = 1'b0;
        last_jp   = jp;
    endtask

    // Acquisition timeout in MEAS_P: no strobe at all.
    task automatic timeout_run();
        logic [5:0] e;
        START     = 1'b1;
        ADC_VALID = 1'b0;
        @(posedge ADC_CLK); #1;
        START = 1'b0;
        for (int c = 1; c <= S+TO+1; c++) begin
            if (c > 1) begin @(posedge ADC_CLK); #1; end
            if      (c <= S)    e = {1'b1, 2'b01, 1'b0, 1'b0, 1'b0};
            else if (c <= S+TO) e = {1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
            else                e = {1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
            @(negedge ADC_CLK);
            chk($sformatf("to_c%0d", c), 64'(ctl_now()), 64'(e));
        end
        chk("to_jp_kept", J_PLUS, last_jp);
        exp_terr = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'(ctl_now()), 64'd0);
        chk({tag, "_jp"}, J_PLUS, 64'd0);
        chk({tag, "_jm"}, J_MINUS, 64'd0);
        chk({tag, "_dj"}, DELTA_J, 64'd0);
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; ADC_VALID = 1'b0; ADC_DATA = '0;
        #2;
        chk_all_zero("rst");
        #10 RST_N = 1'b1;
        idle(2);

        // Nominal: strobes in cycles 7 and 14, result in cycle 16.
        iter(64'h0005_8000_0000_0000, 64'h0003_0000_0000_0000, 3, 3, 1'b0, 1'b0);
        chk("nominal_dj_lit", DELTA_J, 64'h0002_8000_0000_0000);
        idle(2);
        // Negative gradient wraps to two's complement.
        iter(64'h0001_0000_0000_0000, 64'h0002_0000_0000_0000, 2, 1, 1'b0, 1'b0);
        chk("neg_dj_lit", DELTA_J, 64'hFFFF_0000_0000_0000);
        idle(1);
        // Spurious START/ADC_VALID: same timeline as nominal.
        iter(64'h0007_1234_0000_0000, 64'h0007_1234_0000_0001, 3, 3, 1'b1, 1'b0);
        idle(2);
        // Timeout, then the next START clears the flag (checked in iter).
        timeout_run();
        idle(2);
        // Strobe on the last allowed MEAS cycle is a capture.
        iter(64'h0000_0000_0000_0042, 64'h0000_0000_0000_0002, TO, TO, 1'b0, 1'b0);
        idle(1);

        // Reset asserted between edges while in MEAS_M.
        START = 1'b1;
        @(posedge ADC_CLK); #1;
        START = 1'b0;
        for (int c = 1; c <= 2*S+3; c++) begin
            if (c > 1) begin @(posedge ADC_CLK); #1; end
            ADC_VALID = (c == S+1);
            ADC_DATA  = 64'h0000_1111_2222_3333;
        end
        chk("pre_rst_en", 64'(ADC_EN), 64'd1);
        #2 RST_N = 1'b0;
        #1 chk_all_zero("midrst");
        @(negedge ADC_CLK);
        ADC_VALID = 1'b0;
        RST_N     = 1'b1;
        last_jp   = '0;
        exp_terr  = 1'b0;
        idle(2);
        iter(64'h0004_0000_0000_0000, 64'h0001_0000_0000_0000, 2, 2, 1'b0, 1'b0);

        // Back-to-back with START held high.
        iter(64'h0010_0000_0000_0000, 64'h0008_0000_0000_0000, 1, 2, 1'b0, 1'b1);
        iter(64'h0003_0000_0000_0000, 64'h0009_0000_0000_0000, 2, 1, 1'b0, 1'b1);
        START = 1'b0;
        idle(2);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spgd_meas_seq.md
# spgd_meas_seq

Measurement sequencer for one SPGD iteration. On START it applies the positive perturbation, waits a settle interval, and runs one averaged ADC acquisition through the ADC input chain. It then repeats the same steps for the negative perturbation. It captures both 64-bit Q16 metrics and reports J+ − J− to the gradient-update logic. It sits between the SPGD top-level control and the ADC input chain, driving that chain's enable and consuming its write strobe and fixed-point result.

## Interface

Parameters:
- FP_WIDTH, 64, width of the metric word (16 integer bits, FP_WIDTH−16 fraction bits)
- SETTLE_CYCLES, 256, cycles to hold each perturbation before acquisition (≥1)
- TIMEOUT_CYCLES, 65535, maximum cycles to wait for ADC_VALID in a measure state (≥1)
- CNT_WIDTH, 16, width of the shared settle/timeout counter; must hold max(SETTLE_CYCLES, TIMEOUT_CYCLES)

Ports:
- ADC_CLK  input  1  sole clock, rising edge
- RST_N  input  1  asynchronous, active-low reset
- START  input  1  request one iteration; sampled only in IDLE
- BUSY  output  1  high in every state except IDLE
- PERTURB_SEL  output  2  00 = none, 01 = +δ applied, 10 = −δ applied; 11 never driven
- ADC_EN  output  1  enable to ADC input chain; high only in MEAS_P / MEAS_M
- ADC_VALID  input  1  write strobe from ADC input chain
- ADC_DATA  input  FP_WIDTH  Q16 metric from ADC input chain; valid when ADC_VALID is high
- J_PLUS  output  FP_WIDTH  last captured +δ metric
- J_MINUS  output  FP_WIDTH  last captured −δ metric
- DELTA_J  output  FP_WIDTH  J_PLUS − J_MINUS, two's complement
- RESULT_VALID  output  1  one-cycle pulse when DELTA_J updates
- TIMEOUT_ERR  output  1  sticky flag for an acquisition timeout; cleared when the next START is accepted

## Operation

- **Reset:** all outputs are 0, state is IDLE, and the counter is 0. Assertion of RST_N at any time (including mid-iteration) forces this immediately. There is no resumption after reset.
- **States:** IDLE → SETTLE_P → MEAS_P → SETTLE_M → MEAS_M → CALC → IDLE.
- **IDLE:**
  - START=1 → SETTLE_P; load the counter with SETTLE_CYCLES−1; clear TIMEOUT_ERR.
  - ADC_VALID is ignored.
- **SETTLE_P / SETTLE_M:**
  - PERTURB_SEL = 01 / 10; ADC_EN = 0.
  - The counter decrements each cycle.
  - At 0 → MEAS_P / MEAS_M, and the counter reloads with TIMEOUT_CYCLES−1.
- **MEAS_P / MEAS_M:**
  - PERTURB_SEL is held; ADC_EN = 1.
  - ADC_VALID=1 → capture ADC_DATA into J_PLUS / J_MINUS, then go to SETTLE_M (reload SETTLE_CYCLES−1) or CALC.
  - Otherwise the counter decrements. At 0 with no ADC_VALID → IDLE with TIMEOUT_ERR=1, PERTURB_SEL=00, ADC_EN=0, and no RESULT_VALID.
  - ADC_VALID in the same cycle as counter 0 is treated as a capture, not a timeout.
  - On a timeout in MEAS_M, J_PLUS keeps its new value and J_MINUS and DELTA_J are unchanged.
- **CALC:**
  - PERTURB_SEL = 00; ADC_EN = 0.
  - DELTA_J ← J_PLUS − J_MINUS; RESULT_VALID ← 1; → IDLE.
- **Arithmetic:**
  - Inputs are treated as unsigned with MSB 0.
  - The subtraction is full FP_WIDTH two's complement with wrap-around and no saturation.
  - DELTA_J has the same Q16 scaling as the inputs.
- **Other rules:**
  - START while BUSY is ignored; there is no queueing.
  - ADC_VALID outside MEAS states is ignored.
  - START in the RESULT_VALID cycle is accepted.
- J_PLUS, J_MINUS and DELTA_J hold their values until they are overwritten.

## Timing

- All outputs are registered; state changes on the rising ADC_CLK edge.
- With START sampled at edge 0:
  - SETTLE_P occupies cycles 1..SETTLE_CYCLES.
  - MEAS_P begins at cycle SETTLE_CYCLES+1, with ADC_EN rising that cycle.
- ADC_EN falls in the cycle after ADC_VALID is sampled. There is at least SETTLE_CYCLES of ADC_EN low between the two acquisitions.
- PERTURB_SEL changes in the same cycle as the state change; there is no gap cycle between 01 and 10.
- RESULT_VALID is high in the first IDLE cycle after CALC, with BUSY low in that cycle and DELTA_J already valid.
- Total latency from START to RESULT_VALID is 2·SETTLE_CYCLES + Lp + Lm + 2 cycles, where Lp and Lm are the MEAS cycle counts including the ADC_VALID cycle.

## Test plan

- **Nominal iteration:** SETTLE_CYCLES=4; START at cycle 0; ADC_VALID in cycles 7 and 14 with ADC_DATA 0x0005_8000_0000_0000 then 0x0003_0000_0000_0000.
  - SETTLE_P is cycles 1–4; ADC_EN is high 5–7 and 12–14; PERTURB_SEL is 01 in 1–7 and 10 in 8–14.
  - In cycle 16: RESULT_VALID=1 and DELTA_J=0x0002_8000_0000_0000.
- **Negative gradient:** J+=0x0001_0000_0000_0000, J−=0x0002_0000_0000_0000 → DELTA_J=0xFFFF_0000_0000_0000.
- **Timeout:** TIMEOUT_CYCLES=8 with no ADC_VALID in MEAS_P.
  - After 8 MEAS cycles: IDLE, TIMEOUT_ERR=1, PERTURB_SEL=00, ADC_EN=0, and no RESULT_VALID.
  - The next START clears TIMEOUT_ERR.
  - Variant: ADC_VALID arriving in the 8th MEAS cycle is captured normally.
- **Spurious inputs:** ADC_VALID pulses in IDLE and SETTLE, and START pulses mid-iteration → J_PLUS/J_MINUS unchanged by them; the iteration timing is identical to the nominal case.
- **Reset mid-MEAS_M:** RST_N low asynchronously, between clock edges → all outputs are 0 immediately. After release, a START runs a clean full iteration.
- **Back-to-back:** START held high continuously → a new iteration begins in the RESULT_VALID cycle, with SETTLE_P on the following cycle.
